// File: rtl/gpio_in_debounce_pkg.sv
// Shared types and constants for the GPIO input conditioning channels.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gpio_cond_pkg;

  // Per-channel debounce state; 2-bit encoding.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } deb_state_e;

  // Depth of the pad synchroniser in front of each channel FSM.
  localparam int SYNC_STAGES = 2;

  // 1 ms of stable input at a 50 MHz fabric clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/gpio_in_debounce_if.sv
// Bundle of pad inputs and conditioned outputs for the GPIO input stage.
// Latency: n/a (wires only).
// Backpressure: none; levels and strobes are free-running.
interface gpio_in_debounce_if #(
  parameter int WIDTH = 2
);

  logic [WIDTH-1:0] PAD_IN;
  logic [WIDTH-1:0] GPIO_IN;
  logic [WIDTH-1:0] EDGE_RISE;
  logic [WIDTH-1:0] EDGE_FALL;
  logic [WIDTH-1:0] BUSY;

  // Board / stimulus side: drives pads, observes conditioned levels.
  modport master (
    output PAD_IN,
    input  GPIO_IN,
    input  EDGE_RISE,
    input  EDGE_FALL,
    input  BUSY
  );

  // Conditioning block side.
  modport slave (
    input  PAD_IN,
    output GPIO_IN,
    output EDGE_RISE,
    output EDGE_FALL,
    output BUSY
  );

endinterface

// File: rtl/gpio_debounce_chan.sv
// Single-bit pad synchroniser + debounce FSM with registered level, edge strobes and busy flag.
// Latency: clean step reaches lvl_o after SYNC_STAGES + 1 + DEBOUNCE_CYCLES edges.
// Backpressure: none; output level and strobes are unconditional.
module gpio_debounce_chan
  import gpio_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pad_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s2;

  deb_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   lvl_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   busy_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
  assign s2     = sync_q[SYNC_STAGES-1];

  // Shift the raw pad into the clock domain; the FSM only ever sees the last stage.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Debounce FSM: a candidate level must hold for DEBOUNCE_CYCLES+1 samples; any glitch aborts.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (s2) begin
            state_q <= QUAL_HI;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        QUAL_HI: begin
          if (!s2) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            lvl_q   <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!s2) begin
            state_q <= QUAL_LO;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        QUAL_LO: begin
          if (s2) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
          lvl_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/gpio_in_debounce.sv
// Synchronises and debounces WIDTH raw pad inputs for the MSS GPIO_IN pins, plus edge strobes.
// Latency: clean pad step appears on GPIO_IN 2 + DEBOUNCE_CYCLES + 1 edges after first sample.
// Backpressure: none; every channel runs independently and continuously.
module gpio_in_debounce
  import gpio_cond_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               CLK,
  input  logic               RESET_N,
  gpio_in_debounce_if.slave  bus
);

  logic [WIDTH-1:0] lvl_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [WIDTH-1:0] busy_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    gpio_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i   (CLK),
      .rst_n_i (RESET_N),
      .pad_i   (bus.PAD_IN[i]),
      .lvl_o   (lvl_w[i]),
      .rise_o  (rise_w[i]),
      .fall_o  (fall_w[i]),
      .busy_o  (busy_w[i])
    );
  end

  assign bus.GPIO_IN   = lvl_w;
  assign bus.EDGE_RISE = rise_w;
  assign bus.EDGE_FALL = fall_w;
  assign bus.BUSY      = busy_w;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed scenarios plus random pad traffic, checked every cycle against a run-length reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_gpio_in_debounce;

  localparam int W  = 2;
  localparam int DC = 4;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;

  always #5 CLK = ~CLK;

  gpio_in_debounce_if #(.WIDTH(W)) bus ();

  gpio_in_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  // Reference model: a bit flips once the synchronised input has disagreed with
  // the current level for DC+1 consecutive samples; any agreement resets the run.
  logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall, m_busy;
  int           m_run [W];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic model_update(input logic [W-1:0] pad, input logic rst_n);
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_out = '0;
      m_rise = '0; m_fall = '0; m_busy = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (m_s2[i] != m_out[i]) begin
          m_run[i]++;
          if (m_run[i] == DC + 1) begin
            m_out[i]  = m_s2[i];
            m_rise[i] = m_s2[i];
            m_fall[i] = ~m_s2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_busy[i] = (m_run[i] != 0);
      end
      m_s2 = m_s1;
      m_s1 = pad;
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive on the falling edge, advance the model on the rising edge, compare 1 ns later.
  task automatic step(input logic [W-1:0] pad, input logic rst_n);
    @(negedge CLK);
    bus.PAD_IN = pad;
    RESET_N    = rst_n;
    @(posedge CLK);
    cyc++;
    model_update(pad, rst_n);
    #1;
    chk("gpio_in",   bus.GPIO_IN,   m_out);
    chk("edge_rise", bus.EDGE_RISE, m_rise);
    chk("edge_fall", bus.EDGE_FALL, m_fall);
    chk("busy",      bus.BUSY,      m_busy);
    chk("rise_and_fall", bus.EDGE_RISE & bus.EDGE_FALL, '0);
  endtask

  // Hold a pad pattern for n steps; report the 1-based step where GPIO_IN[b] first equals val.
  task automatic hold(input logic [W-1:0] pad, input int b, input logic val, input int n,
                      output int idx, output logic [W-1:0] rise_at, output logic [W-1:0] fall_at,
                      output int nrise_b, output int nfall_any);
    idx = -1; rise_at = '0; fall_at = '0; nrise_b = 0; nfall_any = 0;
    for (int i = 1; i <= n; i++) begin
      step(pad, 1'b1);
      if (bus.EDGE_RISE[b] === 1'b1) nrise_b++;
      if (bus.EDGE_FALL !== '0) nfall_any++;
      if (idx < 0 && bus.GPIO_IN[b] === val) begin
        idx     = i;
        rise_at = bus.EDGE_RISE;
        fall_at = bus.EDGE_FALL;
      end
    end
  endtask

  initial begin
    int           idx, nr, nf, busy_seen, r;
    logic [W-1:0] ra, fa, pad;

    bus.PAD_IN = '0;

    // Reset state
    step(2'b00, 1'b0);
    step(2'b00, 1'b0);
    chk("reset_gpio", bus.GPIO_IN, 2'b00);
    chk("reset_busy", bus.BUSY, 2'b00);
    for (int i = 0; i < 4; i++) step(2'b00, 1'b1);

    // Clean rise on channel 0: exactly 7 edges including the sampling edge
    hold(2'b01, 0, 1'b1, 12, idx, ra, fa, nr, nf);
    chk_int("clean_rise_latency", idx, 7);
    chk("clean_rise_strobe", ra, 2'b01);
    chk_int("clean_rise_count", nr, 1);

    // Glitch on channel 1: 3 cycles high is rejected, busy shows the attempt
    busy_seen = 0;
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(2'b01, 1'b1);
      if (bus.BUSY[1] === 1'b1) busy_seen++;
      chk("glitch_no_rise", bus.EDGE_RISE & 2'b10, 2'b00);
    end
    chk("glitch_gpio", bus.GPIO_IN, 2'b01);
    chk_int("glitch_busy_seen", (busy_seen > 0) ? 1 : 0, 1);

    // Bring channel 1 high, then drop both together
    hold(2'b11, 1, 1'b1, 10, idx, ra, fa, nr, nf);
    chk_int("ch1_rise_latency", idx, 7);
    hold(2'b00, 0, 1'b0, 10, idx, ra, fa, nr, nf);
    chk_int("dual_fall_latency", idx, 7);
    chk("dual_fall_strobe", fa, 2'b11);
    chk_int("dual_fall_count", nf, 1);
    chk("dual_fall_gpio", bus.GPIO_IN, 2'b00);

    // Bounce train on channel 0, then settle high: one rise at settle+7
    nr = 0;
    for (int i = 0; i < 8; i++) begin
      step(((i / 2) % 2 == 0) ? 2'b01 : 2'b00, 1'b1);
      if (bus.EDGE_RISE[0] === 1'b1) nr++;
    end
    chk_int("bounce_no_early_rise", nr, 0);
    hold(2'b01, 0, 1'b1, 12, idx, ra, fa, nr, nf);
    chk_int("bounce_settle_latency", idx, 7);
    chk_int("bounce_rise_count", nr, 1);

    // Reset in the middle of a qualification on channel 0
    hold(2'b00, 0, 1'b0, 10, idx, ra, fa, nr, nf);
    for (int i = 0; i < 5; i++) step(2'b01, 1'b1);
    chk("midqual_busy", bus.BUSY, 2'b01);
    step(2'b01, 1'b0);
    chk("midqual_reset_gpio", bus.GPIO_IN, 2'b00);
    chk("midqual_reset_busy", bus.BUSY, 2'b00);
    hold(2'b01, 0, 1'b1, 12, idx, ra, fa, nr, nf);
    chk_int("midqual_release_latency", idx, 7);
    chk("midqual_release_strobe", ra, 2'b01);

    // Pads held high through reset
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0);
    hold(2'b11, 0, 1'b1, 12, idx, ra, fa, nr, nf);
    chk_int("powerup_latency", idx, 7);
    chk("powerup_strobe", ra, 2'b11);
    chk_int("powerup_no_fall", nf, 0);
    chk("powerup_gpio", bus.GPIO_IN, 2'b11);

    // Random pad traffic with occasional resets, checked cycle by cycle
    pad = 2'b11;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < W; b++) begin
        r = int'($urandom_range(0, 7));
        if (r == 0) pad[b] = ~pad[b];
      end
      step(pad, ($urandom_range(0, 299) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d observed=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
